// File: rtl/aortc_apb_master.sv
// aortc_apb_master: queued APB2 initiator for the always-on RTC domain.
// Commands enter through a valid/ready port into a small FIFO and are
// issued one at a time as zero-wait SETUP/ACCESS transfers. Each completed
// transfer produces a single-cycle response strobe carrying the read data.
module aortc_apb_master #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        pclk,
    input  logic        presetn,
    // Command port
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [2:0]  cmd_prot,
    // Response strobe (no backpressure)
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    // APB2 initiator
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic [2:0]  pprot,
    input  logic [31:0] prdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // One buffered command. Write data is zeroed for reads at push time so
    // the pop path can load pwdata without further qualification.
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  prot;
    } cmd_t;

    cmd_t          mem [FIFO_DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    state_t        state;
    state_t        next_state;

    // FIFO status comes from the registered count only, so a pop in the
    // current cycle cannot raise cmd_ready until the following cycle.
    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem[rd_ptr];
    assign busy      = !empty || (state != IDLE);

    // Command storage write port.
    // NOTE: the storage array carries no reset; an entry is only ever read
    // after it was written, and the count/pointers (which are reset) decide
    // which entries are live, so resetting the data would add nothing.
    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wr_ptr] <= '{write: cmd_write,
                             addr:  cmd_addr,
                             wdata: cmd_write ? cmd_wdata : 32'h0,
                             prot:  cmd_prot};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs regardless of block order.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Transfer FSM state register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state, pop decision and APB phase strobes.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                psel       = 1'b1;
                next_state = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = SETUP;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bus address/data/control: loaded only on a pop, held otherwise.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            pprot  <= '0;
        end else if (pop) begin
            paddr  <= head.addr;
            pwrite <= head.write;
            pwdata <= head.wdata;
            pprot  <= head.prot;
        end
    end

    // Completion strobe: prdata is captured only at the edge ending ACCESS.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= (state == ACCESS);
            if (state == ACCESS) begin
                rsp_write <= pwrite;
                rsp_rdata <= pwrite ? 32'h0 : prdata;
            end
        end
    end

endmodule
